fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared defaults, FSM state codes and timeout word for fetch_unit
package fetch_unit_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_TOUT = 2'd2;

    // Word pushed when a device fetch expires; sliced to DATA_WIDTH by users
    localparam logic [63:0] TOUT_WORD = '1;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction, device and result-buffer signals of fetch_unit
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEV_ID_W   = 3,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] i_ir;
    logic                  i_ir_valid;
    logic                  o_ir_ready;
    logic                  o_dev_req;
    logic [DEV_ID_W-1:0]   o_dev_id;
    logic                  i_dev_ack;
    logic [DATA_WIDTH-1:0] i_dev_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [CW-1:0]         o_count;
    logic                  o_timeout;

    modport slave (
        input  i_ir, i_ir_valid, i_dev_ack, i_dev_data, i_ready,
        output o_ir_ready, o_dev_req, o_dev_id, o_data, o_valid, o_count, o_timeout
    );

    modport master (
        output i_ir, i_ir_valid, i_dev_ack, i_dev_data, i_ready,
        input  o_ir_ready, o_dev_req, o_dev_id, o_data, o_valid, o_count, o_timeout
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - first-word fall-through result buffer for fetch_unit
module fetch_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && (cnt != DEPTH_C);

    // Storage array carries no reset; only occupied slots are ever observed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid   = (cnt != '0);
    assign rd_data = valid ? mem[rd_ptr] : '0;
    assign count   = cnt;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with device read and result FIFO (option FETCH_TIMEOUT_EN)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEV_ID_W   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [DEV_ID_W-1:0]   dev_id_q;
    logic                  ir_ready;
    logic                  accept;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [CW-1:0]         count;
    logic                  fifo_valid;
    logic                  unused_ir;

    assign unused_ir = &{1'b0, bus.i_ir[DATA_WIDTH-1:DEV_ID_W+1]};

    assign ir_ready = (state == ST_IDLE) && (count < DEPTH_C);
    assign accept   = bus.i_ir_valid && ir_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wait_cnt;
    logic          expire;

    assign expire = (state == ST_WAIT) && !bus.i_dev_ack && (wait_cnt == T_LAST);

    // Count unanswered WAIT cycles; cleared whenever the fetch ends or is not active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && !bus.i_dev_ack && !expire) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign bus.o_timeout = (state == ST_TOUT);
`else
    localparam int unused_timeout = TIMEOUT;

    assign bus.o_timeout = 1'b0;
`endif

    // Next-state and FIFO push selection; at most one push per cycle
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.i_ir[0]) state_nxt = ST_WAIT;
                    else             push      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.i_dev_ack) begin
                    push      = 1'b1;
                    push_data = bus.i_dev_data;
                    state_nxt = ST_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (expire) begin
                    state_nxt = ST_TOUT;
                end
`endif
            end
`ifdef FETCH_TIMEOUT_EN
            ST_TOUT: begin
                push      = 1'b1;
                push_data = TOUT_WORD[DATA_WIDTH-1:0];
                state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding device fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Capture the device ID when a device fetch is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_id_q <= '0;
        end else if (accept && bus.i_ir[0]) begin
            dev_id_q <= bus.i_ir[DEV_ID_W:1];
        end
    end

    assign bus.o_ir_ready = ir_ready;
    assign bus.o_dev_req  = (state == ST_WAIT);
    assign bus.o_dev_id   = dev_id_q;
    assign bus.o_valid    = fifo_valid;
    assign bus.o_count    = count;

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.i_ready),
        .rd_data   (bus.o_data),
        .valid     (fifo_valid),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (timeout scenarios with FETCH_TIMEOUT_EN)
module tb_fetch_unit;
    localparam int DW    = 16;
    localparam int IDW   = 3;
    localparam int DEPTH = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if #(.DATA_WIDTH(DW), .DEV_ID_W(IDW), .FIFO_DEPTH(DEPTH)) bus ();

    fetch_unit #(
        .DATA_WIDTH (DW),
        .DEV_ID_W   (IDW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_WAIT, M_TOUT} mode_t;

    mode_t          mode   = M_IDLE;
    logic [DW-1:0]  exp_q[$];
    logic [IDW-1:0] m_id   = '0;
    int             waited = 0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, actual, required, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor and reference model: compare current outputs, then predict the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid",   32'(bus.o_valid),   0);
            chk("rst_count",   32'(bus.o_count),   0);
            chk("rst_dev_req", 32'(bus.o_dev_req), 0);
            chk("rst_dev_id",  32'(bus.o_dev_id),  0);
            chk("rst_data",    32'(bus.o_data),    0);
            chk("rst_timeout", 32'(bus.o_timeout), 0);
            exp_q.delete();
            mode   = M_IDLE;
            m_id   = '0;
            waited = 0;
        end else begin
            int sz;
            bit acc;
            sz  = exp_q.size();
            acc = bus.i_ir_valid && (mode == M_IDLE) && (sz < DEPTH);
            chk("count",    32'(bus.o_count),    32'(sz));
            chk("valid",    32'(bus.o_valid),    32'(sz != 0));
            chk("ir_ready", 32'(bus.o_ir_ready), 32'((mode == M_IDLE) && (sz < DEPTH)));
            chk("dev_req",  32'(bus.o_dev_req),  32'(mode == M_WAIT));
            chk("dev_id",   32'(bus.o_dev_id),   32'(m_id));
            chk("timeout",  32'(bus.o_timeout),  32'(mode == M_TOUT));
            if (sz > 0 && bus.i_ready) begin
                chk("pop_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
            end
            case (mode)
                M_IDLE: begin
                    if (acc) begin
                        if (bus.i_ir[0]) begin
                            mode   = M_WAIT;
                            m_id   = bus.i_ir[IDW:1];
                            waited = 0;
                        end else begin
                            exp_q.push_back('0);
                        end
                    end
                end
                M_WAIT: begin
                    if (bus.i_dev_ack) begin
                        exp_q.push_back(bus.i_dev_data);
                        mode = M_IDLE;
                    end else begin
                        waited++;
`ifdef FETCH_TIMEOUT_EN
                        if (waited == TMO) mode = M_TOUT;
`endif
                    end
                end
                default: begin
                    exp_q.push_back({DW{1'b1}});
                    mode = M_IDLE;
                end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_ir       = '0;
        bus.i_ir_valid = 1'b0;
        bus.i_dev_ack  = 1'b0;
        bus.i_dev_data = '0;
        bus.i_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.o_ir_ready), 1);

        // Device fetch from dev 3, ack two cycles after acceptance
        bus.i_ir = 16'h0007; bus.i_ir_valid = 1'b1;
        tick();
        bus.i_ir_valid = 1'b0;
        @(negedge clk);
        chk("s1_dev_req", 32'(bus.o_dev_req), 1);
        chk("s1_dev_id",  32'(bus.o_dev_id),  3);
        tick();
        bus.i_dev_ack = 1'b1; bus.i_dev_data = 16'hBEEF;
        tick();
        bus.i_dev_ack = 1'b0;
        @(negedge clk);
        chk("s1_valid",   32'(bus.o_valid),   1);
        chk("s1_data",    32'(bus.o_data),    32'h0000_BEEF);
        chk("s1_req_off", 32'(bus.o_dev_req), 0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // Zero fetch
        bus.i_ir = 16'h0006; bus.i_ir_valid = 1'b1;
        tick();
        bus.i_ir_valid = 1'b0;
        @(negedge clk);
        chk("s2_valid",   32'(bus.o_valid),   1);
        chk("s2_data",    32'(bus.o_data),    0);
        chk("s2_dev_req", 32'(bus.o_dev_req), 0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // Fill the FIFO back-to-back, then one pop frees a slot
        bus.i_ir = 16'h0000; bus.i_ir_valid = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("s3_count_full", 32'(bus.o_count),    4);
        chk("s3_ready_full", 32'(bus.o_ir_ready), 0);
        tick();
        bus.i_ir_valid = 1'b0;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        @(negedge clk);
        chk("s3_ready_pop", 32'(bus.o_ir_ready), 1);
        chk("s3_count_pop", 32'(bus.o_count),    3);
        bus.i_ready = 1'b1;
        repeat (3) tick();
        bus.i_ready = 1'b0;

        // Reset in the middle of a device fetch, late ack must be ignored
        bus.i_ir = 16'h0005; bus.i_ir_valid = 1'b1;
        tick();
        bus.i_ir_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("s6_req_drop", 32'(bus.o_dev_req), 0);
        tick();
        rst_n = 1'b1;
        bus.i_dev_ack = 1'b1; bus.i_dev_data = 16'h1234;
        tick();
        bus.i_dev_ack = 1'b0;
        @(negedge clk);
        chk("s6_count", 32'(bus.o_count), 0);
        chk("s6_valid", 32'(bus.o_valid), 0);

`ifdef FETCH_TIMEOUT_EN
        begin
            bit found;
            int lat;
            found = 1'b0;
            lat   = 0;
            bus.i_ir = 16'h0003; bus.i_ir_valid = 1'b1;
            tick();
            bus.i_ir_valid = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (bus.o_timeout) begin
                    found = 1'b1;
                    lat   = c;
                end else begin
                    tick();
                end
            end
            chk("s4_tmo_seen",    32'(found), 1);
            chk("s4_tmo_latency", 32'(lat),   32'(TMO));
            tick();
            @(negedge clk);
            chk("s4_data",    32'(bus.o_data),     32'h0000_FFFF);
            chk("s4_pulse",   32'(bus.o_timeout),  0);
            chk("s4_idle",    32'(bus.o_ir_ready), 1);
            bus.i_ready = 1'b1;
            tick();
            bus.i_ready = 1'b0;
        end

        // Ack on the expiry cycle wins over the timeout
        bus.i_ir = 16'h000B; bus.i_ir_valid = 1'b1;
        tick();
        bus.i_ir_valid = 1'b0;
        repeat (TMO - 1) tick();
        bus.i_dev_ack = 1'b1; bus.i_dev_data = 16'hCAFE;
        tick();
        bus.i_dev_ack = 1'b0;
        @(negedge clk);
        chk("s5_timeout", 32'(bus.o_timeout), 0);
        chk("s5_data",    32'(bus.o_data),    32'h0000_CAFE);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
`else
        // Without the timeout option a fetch waits indefinitely
        bus.i_ir = 16'h000D; bus.i_ir_valid = 1'b1;
        tick();
        bus.i_ir_valid = 1'b0;
        repeat (300) tick();
        @(negedge clk);
        chk("s4_still_wait", 32'(bus.o_dev_req), 1);
        chk("s4_no_timeout", 32'(bus.o_timeout), 0);
        bus.i_dev_ack = 1'b1; bus.i_dev_data = 16'h5A5A;
        tick();
        bus.i_dev_ack = 1'b0;
        @(negedge clk);
        chk("s4_late_data", 32'(bus.o_data), 32'h0000_5A5A);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
`endif

        // Randomized traffic, including acks outside WAIT and occasional resets
        for (int n = 0; n < 3000; n++) begin
            bus.i_ir       = 16'($urandom);
            bus.i_ir_valid = ($urandom_range(0, 1) == 1);
            bus.i_ready    = ($urandom_range(0, 4) < 2);
            bus.i_dev_ack  = ($urandom_range(0, 5) == 0);
            bus.i_dev_data = 16'($urandom);
            rst_n          = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n          = 1'b1;
        bus.i_ir_valid = 1'b0;
        bus.i_dev_ack  = 1'b0;
        bus.i_ready    = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
